// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the router output-port arbiters.
// Also used by the VC allocator.
package noc_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam logic [0:0] ST_IDLE   = ARB_IDLE;
    localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

    localparam int NOC_PORTS  = 5;
    localparam int PORT_LOCAL = 0;
    localparam int PORT_N     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_S     = 3;
    localparam int PORT_W     = 4;

    // Callers truncate the result to their own port count; an out-of-range index gives zero.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
        logic [31:0] v;
        if (idx < n) begin
            v = 32'd1 << idx;
        end else begin
            v = 32'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/noc_out_port_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
interface noc_out_port_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int N_IN  = NOC_PORTS,
    parameter int IDX_W = $clog2(N_IN)
) ();
    logic [N_IN-1:0]  req;
    logic [N_IN-1:0]  tail;
    logic             out_ready;
    logic [N_IN-1:0]  select;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             fire;

    modport master (
        output req, tail, out_ready,
        input  select, grant_valid, grant_idx, fire
    );

    modport slave (
        input  req, tail, out_ready,
        output select, grant_valid, grant_idx, fire
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: lowest set bit of (req & ~mask) at or above ptr, wrapping.
// The request vector is doubled so the wrap-around needs no modulo arithmetic.
module rr_priority_pick #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);
    logic [N-1:0]   eff_s;
    logic [2*N-1:0] dbl_s;
    logic [IDX_W:0] pos_s;

    assign eff_s = req & ~mask;
    assign any   = |eff_s;

    // Lower copy drops bits below the pointer; the upper copy supplies the wrapped part.
    always_comb begin
        dbl_s = {(2*N){1'b0}};
        for (int k = 0; k < N; k++) begin
            dbl_s[k]     = eff_s[k] & (~rr_mode | (IDX_W'(k) >= ptr));
            dbl_s[k + N] = eff_s[k];
        end
        pos_s = {(IDX_W+1){1'b0}};
        for (int k = 2*N-1; k >= 0; k--) begin
            pos_s = dbl_s[k] ? (IDX_W+1)'(k) : pos_s;
        end
        if (pos_s >= (IDX_W+1)'(N)) begin
            win_idx = IDX_W'(pos_s - (IDX_W+1)'(N));
        end else begin
            win_idx = IDX_W'(pos_s);
        end
    end
endmodule

// File: rtl/noc_out_port_arbiter.sv
// Output-port arbiter: picks one input per packet and locks the crossbar
// select from head flit to accepted tail flit.
module noc_out_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N_IN    = NOC_PORTS,
    parameter int RR_MODE = 1,
    parameter int IDX_W   = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_out_port_arbiter_if.slave bus
);
    logic [0:0]       state_q, state_d;
    logic [N_IN-1:0]  select_q, select_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] win_idx_s;
    logic [N_IN-1:0]  owner_mask_s;
    logic             any_s, fire_s, release_s;

    assign fire_s       = grant_valid_q & bus.req[grant_idx_q] & bus.out_ready;
    assign release_s    = fire_s & bus.tail[grant_idx_q];
    assign owner_mask_s = grant_valid_q ? N_IN'(onehot(32'(grant_idx_q), N_IN)) : {N_IN{1'b0}};

    // Pointer moves past the owner only on tail transfer; explicit wrap for non power-of-two N_IN.
    always_comb begin
        if (release_s && (RR_MODE != 0)) begin
            if (grant_idx_q == IDX_W'(N_IN - 1)) begin
                rr_ptr_d = {IDX_W{1'b0}};
            end else begin
                rr_ptr_d = grant_idx_q + IDX_W'(1'b1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    rr_priority_pick #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .mask    (owner_mask_s),
        .ptr     (rr_ptr_d),
        .rr_mode (RR_MODE != 0),
        .any     (any_s),
        .win_idx (win_idx_s)
    );

    // Grant from IDLE, or hand over on the tail edge with the old owner masked out.
    always_comb begin
        state_d       = state_q;
        select_d      = select_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d       = ST_LOCKED;
                    select_d      = N_IN'(onehot(32'(win_idx_s), N_IN));
                    grant_valid_d = 1'b1;
                    grant_idx_d   = win_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (release_s && any_s) begin
                    select_d    = N_IN'(onehot(32'(win_idx_s), N_IN));
                    grant_idx_d = win_idx_s;
                end else if (release_s) begin
                    state_d       = ST_IDLE;
                    select_d      = {N_IN{1'b0}};
                    grant_valid_d = 1'b0;
                    grant_idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                select_d      = {N_IN{1'b0}};
                grant_valid_d = 1'b0;
                grant_idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            select_q      <= {N_IN{1'b0}};
            grant_valid_q <= 1'b0;
            grant_idx_q   <= {IDX_W{1'b0}};
            rr_ptr_q      <= {IDX_W{1'b0}};
        end else begin
            state_q       <= state_d;
            select_q      <= select_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.select      = select_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.fire        = fire_s;
endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Bench for noc_out_port_arbiter: directed scenarios plus random traffic
// on three configurations, checked against a packet-level reference model.
module tb_noc_out_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    noc_out_port_arbiter_if #(.N_IN(5)) b0 ();
    noc_out_port_arbiter_if #(.N_IN(5)) b1 ();
    noc_out_port_arbiter_if #(.N_IN(3)) b3 ();

    noc_out_port_arbiter #(.N_IN(5), .RR_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    noc_out_port_arbiter #(.N_IN(5), .RR_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    noc_out_port_arbiter #(.N_IN(3), .RR_MODE(1)) u3 (.clk(clk), .rst(rst), .bus(b3));

    // Index 0: fixed priority N=5, 1: round robin N=5, 2: round robin N=3
    logic [4:0]  q_req  [3];
    logic [4:0]  q_tail [3];
    logic        q_rdy  [3];
    logic [31:0] d_sel  [3];
    logic [31:0] d_idx  [3];
    logic        d_gv   [3];
    logic        d_fire [3];

    assign q_req[0]  = b0.req;            assign q_req[1]  = b1.req;            assign q_req[2]  = {2'b00, b3.req};
    assign q_tail[0] = b0.tail;           assign q_tail[1] = b1.tail;           assign q_tail[2] = {2'b00, b3.tail};
    assign q_rdy[0]  = b0.out_ready;      assign q_rdy[1]  = b1.out_ready;      assign q_rdy[2]  = b3.out_ready;
    assign d_sel[0]  = {27'd0, b0.select};    assign d_sel[1] = {27'd0, b1.select};    assign d_sel[2] = {29'd0, b3.select};
    assign d_idx[0]  = {29'd0, b0.grant_idx}; assign d_idx[1] = {29'd0, b1.grant_idx}; assign d_idx[2] = {30'd0, b3.grant_idx};
    assign d_gv[0]   = b0.grant_valid;    assign d_gv[1]   = b1.grant_valid;    assign d_gv[2]   = b3.grant_valid;
    assign d_fire[0] = b0.fire;           assign d_fire[1] = b1.fire;           assign d_fire[2] = b3.fire;

    // Reference model: owner port (-1 = none) and the next port to be favoured.
    int m_own [3];
    int m_ptr [3];

    function automatic int n_of(int j);
        return (j == 2) ? 3 : 5;
    endfunction

    function automatic bit rr_of(int j);
        return (j != 0);
    endfunction

    function automatic int pick(int n, bit rr, int ptr, logic [4:0] r, int skip);
        int w;
        w = -1;
        for (int k = n - 1; k >= 0; k--) begin
            int i;
            i = rr ? (ptr + k) % n : k;
            if (r[i] && (i != skip)) w = i;
        end
        return w;
    endfunction

    function automatic bit tail_done(int j);
        int o;
        o = m_own[j];
        if (o < 0) return 1'b0;
        return q_req[j][o] && q_tail[j][o] && q_rdy[j];
    endfunction

    function automatic int nxt_ptr(int j);
        if (tail_done(j)) return rr_of(j) ? (m_own[j] + 1) % n_of(j) : 0;
        return m_ptr[j];
    endfunction

    function automatic int nxt_own(int j);
        if (m_own[j] < 0) return pick(n_of(j), rr_of(j), m_ptr[j], q_req[j], -1);
        if (tail_done(j)) return pick(n_of(j), rr_of(j), nxt_ptr(j), q_req[j], m_own[j]);
        return m_own[j];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 3; j++) begin
                m_own[j] <= -1;
                m_ptr[j] <= 0;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                m_own[j] <= nxt_own(j);
                m_ptr[j] <= nxt_ptr(j);
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_chk(string tag);
        for (int j = 0; j < 3; j++) begin
            int o;
            logic ef;
            o  = m_own[j];
            ef = (o >= 0) ? (q_req[j][o] & q_rdy[j] & ~rst) : 1'b0;
            chk($sformatf("%s u%0d sel", tag, j),  d_sel[j], (o >= 0) ? (32'd1 << o) : 32'd0);
            chk($sformatf("%s u%0d gv", tag, j),   {31'd0, d_gv[j]}, {31'd0, (o >= 0)});
            chk($sformatf("%s u%0d idx", tag, j),  d_idx[j], (o >= 0) ? 32'(o) : 32'd0);
            chk($sformatf("%s u%0d fire", tag, j), {31'd0, d_fire[j]}, {31'd0, ef});
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        @(negedge clk);
        model_chk(tag);
    endtask

    initial begin
        b0.req = 5'd0; b0.tail = 5'd0; b0.out_ready = 1'b0;
        b1.req = 5'd0; b1.tail = 5'd0; b1.out_ready = 1'b0;
        b3.req = 3'd0; b3.tail = 3'd0; b3.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_chk("reset");
        chk("reset sel", d_sel[1], 32'd0);
        chk("reset gv", {31'd0, d_gv[1]}, 32'd0);
        rst = 1'b0;

        // Fixed priority: lowest index wins and the lock ignores other requesters
        b0.req = 5'b10110; b0.tail = 5'd0; b0.out_ready = 1'b1;
        tick("fp grant");
        chk("fp sel", d_sel[0], 32'b00010);
        chk("fp idx", d_idx[0], 32'd1);
        chk("fp gv", {31'd0, d_gv[0]}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            b0.req = {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0};
            tick("fp hold");
            chk("fp hold sel", d_sel[0], 32'b00010);
        end
        b0.req = 5'b10110; b0.tail = 5'b00010;
        tick("fp handover");
        chk("fp handover idx", d_idx[0], 32'd2);
        b0.req = 5'd0; b0.tail = 5'd0;

        // Round robin: every flit a tail, all requesting
        b1.req = 5'b11111; b1.tail = 5'b11111; b1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick("rr rot");
            chk("rr rot idx", d_idx[1], 32'(k % 5));
            chk("rr rot gv", {31'd0, d_gv[1]}, 32'd1);
        end
        b1.req = 5'b00001; b1.tail = 5'b00001;
        tick("rr drain");
        chk("rr drain gv", {31'd0, d_gv[1]}, 32'd0);

        // Backpressure on the tail flit of owner 3
        b1.req = 5'b01000; b1.tail = 5'd0;
        tick("bp grant");
        chk("bp sel", d_sel[1], 32'b01000);
        b1.tail = 5'b01000; b1.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick("bp stall");
            chk("bp stall sel", d_sel[1], 32'b01000);
            chk("bp stall fire", {31'd0, d_fire[1]}, 32'd0);
        end
        b1.out_ready = 1'b1;
        #1;
        chk("bp tail fire", {31'd0, d_fire[1]}, 32'd1);
        tick("bp release");
        chk("bp release sel", d_sel[1], 32'd0);
        b1.req = 5'd0; b1.tail = 5'd0;

        // Packet bubble on owner 2 while input 0 waits
        b1.req = 5'b00100;
        tick("bub grant");
        chk("bub sel", d_sel[1], 32'b00100);
        b1.req = 5'b00001;
        for (int c = 0; c < 3; c++) begin
            tick("bub gap");
            chk("bub gap sel", d_sel[1], 32'b00100);
            chk("bub gap fire", {31'd0, d_fire[1]}, 32'd0);
        end
        b1.req = 5'b00101;
        tick("bub body");
        chk("bub body sel", d_sel[1], 32'b00100);
        b1.tail = 5'b00100;
        #1;
        chk("bub tail fire", {31'd0, d_fire[1]}, 32'd1);
        tick("bub handover");
        chk("bub handover sel", d_sel[1], 32'b00001);
        chk("bub handover gv", {31'd0, d_gv[1]}, 32'd1);

        // Async reset while input 4 owns the port
        b1.req = 5'b00001; b1.tail = 5'b00001;
        tick("ar drain");
        chk("ar drain gv", {31'd0, d_gv[1]}, 32'd0);
        b1.req = 5'b10000; b1.tail = 5'd0;
        tick("ar grant");
        chk("ar idx4", d_idx[1], 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("ar sel", d_sel[1], 32'd0);
        chk("ar gv", {31'd0, d_gv[1]}, 32'd0);
        chk("ar idx", d_idx[1], 32'd0);
        chk("ar fire", {31'd0, d_fire[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        b1.req = 5'b10001;
        tick("ar regrant");
        chk("ar regrant idx", d_idx[1], 32'd0);
        b1.req = 5'd0;

        // Three-port wrap: owner 2 hands over to 0 without an idle cycle
        b3.req = 3'b100; b3.tail = 3'b000; b3.out_ready = 1'b1;
        tick("wrap grant");
        chk("wrap idx2", d_idx[2], 32'd2);
        b3.req = 3'b101; b3.tail = 3'b100;
        @(posedge clk);
        #1;
        chk("wrap no gap", d_sel[2], 32'b001);
        @(negedge clk);
        model_chk("wrap");
        chk("wrap idx0", d_idx[2], 32'd0);

        // Random traffic on all three instances
        for (int c = 0; c < 400; c++) begin
            b0.req  = 5'($urandom); b0.tail = 5'($urandom); b0.out_ready = ($urandom_range(0, 3) != 0);
            b1.req  = 5'($urandom); b1.tail = 5'($urandom); b1.out_ready = ($urandom_range(0, 3) != 0);
            b3.req  = 3'($urandom); b3.tail = 3'($urandom); b3.out_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
